// File: rtl/nor_logic_sequencer.sv
// nor_logic_sequencer
// Computes NOR/OR/NOT/AND/XNOR/XOR on 32-bit operands by running one or
// more passes through a shared external NOR array. It drives the array
// operands from registers and captures the array output on the next edge.
// Illegal opcodes take one dead cycle with zero operands so that their
// latency matches the single-pass ops. They then report err with a zero result.
module nor_logic_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_inA,
  input  logic [31:0] i_inB,
  output logic [31:0] o_norA,
  output logic [31:0] o_norB,
  input  logic [31:0] i_norC,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_outC,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [2:0] OP_NOR  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XNOR = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [2:0]  r_op;
  logic [2:0]  r_pass;
  logic [31:0] r_t1;
  logic [31:0] r_t2;
  logic [31:0] r_outC;
  logic        r_err;
  logic [31:0] r_norA;
  logic [31:0] r_norB;

  state_t      w_state;
  logic [31:0] w_opA;
  logic [31:0] w_opB;
  logic [2:0]  w_op;
  logic [2:0]  w_pass;
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_outC;
  logic        w_err;
  logic [31:0] w_norA;
  logic [31:0] w_norB;
  logic        w_finish;
  logic        w_finErr;

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opA   <= '0;
      r_opB   <= '0;
      r_op    <= '0;
      r_pass  <= '0;
      r_t1    <= '0;
      r_t2    <= '0;
      r_outC  <= '0;
      r_err   <= 1'b0;
      r_norA  <= '0;
      r_norB  <= '0;
    end else begin
      r_state <= w_state;
      r_opA   <= w_opA;
      r_opB   <= w_opB;
      r_op    <= w_op;
      r_pass  <= w_pass;
      r_t1    <= w_t1;
      r_t2    <= w_t2;
      r_outC  <= w_outC;
      r_err   <= w_err;
      r_norA  <= w_norA;
      r_norB  <= w_norB;
    end
  end

  // Next state plus the pass schedule. Each pass captures the NOR output
  // and loads the operands for the following pass in the same edge.
  // The freshly captured value feeds the next operands directly from i_norC.
  always_comb begin
    w_state  = r_state;
    w_opA    = r_opA;
    w_opB    = r_opB;
    w_op     = r_op;
    w_pass   = r_pass;
    w_t1     = r_t1;
    w_t2     = r_t2;
    w_outC   = r_outC;
    w_err    = r_err;
    w_norA   = r_norA;
    w_norB   = r_norB;
    w_finish = 1'b0;
    w_finErr = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_opA   = i_inA;
          w_opB   = i_inB;
          w_op    = i_op;
          w_pass  = 3'd1;
          w_state = S_PASS;
          case (i_op)
            OP_NOT, OP_AND: begin
              w_norA = i_inA;
              w_norB = i_inA;
            end
            OP_NOR, OP_OR, OP_XNOR, OP_XOR: begin
              w_norA = i_inA;
              w_norB = i_inB;
            end
            default: begin
              w_norA = '0;
              w_norB = '0;
            end
          endcase
        end
      end

      S_PASS: begin
        w_pass = r_pass + 3'd1;
        case (r_op)
          OP_NOR, OP_NOT: w_finish = 1'b1;
          OP_OR: begin
            if (r_pass == 3'd1) begin
              w_t1   = i_norC;
              w_norA = i_norC;
              w_norB = i_norC;
            end else begin
              w_finish = 1'b1;
            end
          end
          OP_AND: begin
            case (r_pass)
              3'd1: begin
                w_t1   = i_norC;
                w_norA = r_opB;
                w_norB = r_opB;
              end
              3'd2: begin
                w_t2   = i_norC;
                w_norA = r_t1;
                w_norB = i_norC;
              end
              default: w_finish = 1'b1;
            endcase
          end
          OP_XNOR, OP_XOR: begin
            case (r_pass)
              3'd1: begin
                w_t1   = i_norC;
                w_norA = r_opA;
                w_norB = i_norC;
              end
              3'd2: begin
                w_t2   = i_norC;
                w_norA = r_opB;
                w_norB = r_t1;
              end
              3'd3: begin
                w_t1   = i_norC;
                w_norA = r_t2;
                w_norB = i_norC;
              end
              3'd4: begin
                if (r_op == OP_XOR) begin
                  w_t1   = i_norC;
                  w_norA = i_norC;
                  w_norB = i_norC;
                end else begin
                  w_finish = 1'b1;
                end
              end
              default: w_finish = 1'b1;
            endcase
          end
          default: begin
            w_finish = 1'b1;
            w_finErr = 1'b1;
          end
        endcase

        if (w_finish) begin
          w_outC  = w_finErr ? 32'd0 : i_norC;
          w_err   = w_finErr;
          w_norA  = '0;
          w_norB  = '0;
          w_pass  = '0;
          w_state = S_DONE;
        end
      end

      S_DONE: begin
        if (i_out_ready) begin
          w_state = S_IDLE;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state == S_PASS) || (r_state == S_DONE);
  assign o_norA      = r_norA;
  assign o_norB      = r_norB;
  assign o_outC      = r_outC;
  assign o_err       = r_err;

endmodule

// File: tb/tb_nor_logic_sequencer.sv
// tb_nor_logic_sequencer
// Bench for nor_logic_sequencer with a behavioural NOR array and a
// transaction-level reference model checked every cycle.
module tb_nor_logic_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_PASS = 1;
  localparam int M_DONE = 2;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [2:0]  i_op;
  logic [31:0] i_inA;
  logic [31:0] i_inB;
  logic [31:0] o_norA;
  logic [31:0] o_norB;
  logic [31:0] i_norC;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_outC;
  logic        o_err;
  logic        o_busy;

  int numCompared;
  int numMismatched;
  int numDelivered;
  bit randStall;

  int          mState;
  int          mK;
  int          mN;
  logic [31:0] mPA [1:5];
  logic [31:0] mPB [1:5];
  logic [31:0] mExp;
  logic        mExpErr;
  logic [31:0] mHeld;

  nor_logic_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_op        (i_op),
    .i_inA       (i_inA),
    .i_inB       (i_inB),
    .o_norA      (o_norA),
    .o_norB      (o_norB),
    .i_norC      (i_norC),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_outC      (o_outC),
    .o_err       (o_err),
    .o_busy      (o_busy)
  );

  // The shared NOR array the sequencer time-shares
  assign i_norC = ~(o_norA | o_norB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: final result from plain logic ops, plus the operand
  // pairs each pass must present, worked out from A and B directly.
  task automatic buildModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] n;
    n = ~(a | b);
    mExpErr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      mPA[i] = '0;
      mPB[i] = '0;
    end
    case (op)
      3'd0: begin mN = 1; mPA[1] = a; mPB[1] = b; mExp = ~(a | b); end
      3'd1: begin mN = 2; mPA[1] = a; mPB[1] = b; mPA[2] = n; mPB[2] = n; mExp = a | b; end
      3'd2: begin mN = 1; mPA[1] = a; mPB[1] = a; mExp = ~a; end
      3'd3: begin
        mN = 3;
        mPA[1] = a;  mPB[1] = a;
        mPA[2] = b;  mPB[2] = b;
        mPA[3] = ~a; mPB[3] = ~b;
        mExp = a & b;
      end
      3'd4, 3'd5: begin
        mN = (op == 3'd4) ? 4 : 5;
        mPA[1] = a;          mPB[1] = b;
        mPA[2] = a;          mPB[2] = n;
        mPA[3] = b;          mPB[3] = n;
        mPA[4] = ~(a | n);   mPB[4] = ~(b | n);
        mPA[5] = ~(a ^ b);   mPB[5] = ~(a ^ b);
        mExp = (op == 3'd4) ? ~(a ^ b) : (a ^ b);
      end
      default: begin mN = 1; mExp = '0; mExpErr = 1'b1; end
    endcase
  endtask

  // Compare every DUT output against the model mid-cycle, then step the
  // model to what the next rising edge must produce
  always @(negedge clk) begin
    if (!rst_n) begin
      mState = M_IDLE;
      mK     = 0;
      mHeld  = '0;
      checkOutput("rstInReady", {31'd0, o_in_ready}, 32'd1);
      checkOutput("rstOutValid", {31'd0, o_out_valid}, 32'd0);
      checkOutput("rstBusy", {31'd0, o_busy}, 32'd0);
      checkOutput("rstNorA", o_norA, 32'd0);
      checkOutput("rstNorB", o_norB, 32'd0);
      checkOutput("rstOutC", o_outC, 32'd0);
    end else begin
      checkOutput("inReady", {31'd0, o_in_ready}, {31'd0, mState == M_IDLE});
      checkOutput("outValid", {31'd0, o_out_valid}, {31'd0, mState == M_DONE});
      checkOutput("busy", {31'd0, o_busy}, {31'd0, mState != M_IDLE});
      checkOutput("outC", o_outC, mHeld);
      if (mState == M_PASS) begin
        checkOutput("norA", o_norA, mPA[mK]);
        checkOutput("norB", o_norB, mPB[mK]);
      end else begin
        checkOutput("norAIdle", o_norA, 32'd0);
        checkOutput("norBIdle", o_norB, 32'd0);
      end
      if (mState == M_DONE) begin
        checkOutput("err", {31'd0, o_err}, {31'd0, mExpErr});
      end

      case (mState)
        M_IDLE: begin
          if (i_in_valid) begin
            buildModel(i_op, i_inA, i_inB);
            mK = 1;
            mState = M_PASS;
          end
        end
        M_PASS: begin
          if (mK == mN) begin
            mState = M_DONE;
            mHeld  = mExp;
          end else begin
            mK++;
          end
        end
        default: begin
          if (i_out_ready) begin
            numDelivered++;
            mState = M_IDLE;
          end
        end
      endcase
    end
  end

  // One clock step; leaves the caller just after the rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (randStall) begin
      i_out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    i_op       = op;
    i_inA      = a;
    i_inB      = b;
    i_in_valid = 1'b1;
    while (!o_in_ready && n < 200) begin
      stepCycle();
      n++;
    end
    if (!o_in_ready) begin
      numCompared++;
      numMismatched++;
      $display("[TB] FAIL acceptTimeout: in_ready=%0b after %0d cycles, required 1", o_in_ready, n);
    end else begin
      stepCycle();
    end
    i_in_valid = 1'b0;
  endtask

  task automatic runDirected(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expC, input int expLat,
                             input logic expErr);
    int cnt;
    applyStimulus(op, a, b);
    cnt = 0;
    while (!o_out_valid && cnt < 20) begin
      stepCycle();
      cnt++;
    end
    checkOutput({name, "Latency"}, cnt, expLat);
    checkOutput({name, "OutC"}, o_outC, expC);
    checkOutput({name, "Err"}, {31'd0, o_err}, {31'd0, expErr});
    stepCycle();
  endtask

  // Directed cases, backpressure, async reset mid-op, illegal ops, then random traffic
  initial begin
    int cnt;
    int startDelivered;
    numCompared   = 0;
    numMismatched = 0;
    numDelivered  = 0;
    randStall     = 1'b0;
    rst_n         = 1'b0;
    i_in_valid    = 1'b0;
    i_op          = '0;
    i_inA         = '0;
    i_inB         = '0;
    i_out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    runDirected("nor",  3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1, 1'b0);
    runDirected("not",  3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 1, 1'b0);
    runDirected("or",   3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 2, 1'b0);
    runDirected("and",  3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 3, 1'b0);
    runDirected("xnor", 3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 4, 1'b0);
    runDirected("xor",  3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5, 1'b0);

    $display("[TB] backpressure");
    i_out_ready = 1'b0;
    applyStimulus(3'd5, 32'hF0F0F0F0, 32'hFF00FF00);
    cnt = 0;
    while (!o_out_valid && cnt < 20) begin
      stepCycle();
      cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpOutC", o_outC, 32'h0FF00FF0);
      checkOutput("bpInReady", {31'd0, o_in_ready}, 32'd0);
      checkOutput("bpOutValid", {31'd0, o_out_valid}, 32'd1);
      i_inA = $urandom;
      i_inB = $urandom;
      stepCycle();
    end
    i_out_ready = 1'b1;
    stepCycle();
    checkOutput("bpReleaseInReady", {31'd0, o_in_ready}, 32'd1);
    checkOutput("bpReleaseOutValid", {31'd0, o_out_valid}, 32'd0);

    $display("[TB] async reset during XOR pass 3");
    applyStimulus(3'd5, 32'h12345678, 32'h9ABCDEF0);
    stepCycle();
    stepCycle();
    checkOutput("preRstNorA", o_norA, 32'h9ABCDEF0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady", {31'd0, o_in_ready}, 32'd1);
    checkOutput("midRstOutValid", {31'd0, o_out_valid}, 32'd0);
    checkOutput("midRstNorA", o_norA, 32'd0);
    checkOutput("midRstNorB", o_norB, 32'd0);
    checkOutput("midRstOutC", o_outC, 32'd0);
    checkOutput("midRstBusy", {31'd0, o_busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    runDirected("postRstNor", 3'd0, 32'h0000FFFF, 32'h00FF00FF, 32'hFF0000F0 & 32'hFF00FF00 | 32'h0, 1, 1'b0);

    runDirected("illegal6", 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1);
    runDirected("illegal7", 3'd7, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1, 1'b1);
    runDirected("orAfterErr", 3'd1, 32'h00000001, 32'h80000000, 32'h80000001, 2, 1'b0);

    $display("[TB] random back-to-back");
    startDelivered = numDelivered;
    randStall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    randStall   = 1'b0;
    i_out_ready = 1'b1;
    cnt = 0;
    while (!o_in_ready && cnt < 50) begin
      stepCycle();
      cnt++;
    end
    stepCycle();
    checkOutput("randDelivered", numDelivered - startDelivered, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
